// File: rtl/fir_pkg.sv
// Shared types, default sizing and helpers for the FIR sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } fir_seq_state_t;

  localparam int unsigned FIR_DW  = 32;
  localparam int unsigned FIR_AW  = 5;
  localparam int unsigned FIR_LAT = 8;
  localparam int unsigned FIR_CLR = 10;

  // Requested sample counts beyond the buffer depth run the whole buffer.
  function automatic int unsigned fir_clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Buffer and filter datapath bus between the sequencer and its surroundings.
// Signal direction suffixes are as seen from the sequencer (master side).
interface fir_seq_ctrl_if #(
  parameter int unsigned DW = fir_pkg::FIR_DW,
  parameter int unsigned AW = fir_pkg::FIR_AW
);

  logic [AW-1:0] xbuf_addr_o;
  logic [DW-1:0] xbuf_dat_i;
  logic [DW-1:0] fir_in_o;
  logic [DW-1:0] fir_out_i;
  logic          ybuf_we_o;
  logic [AW-1:0] ybuf_addr_o;
  logic [DW-1:0] ybuf_dat_o;

  modport master (
    output xbuf_addr_o,
    output fir_in_o,
    output ybuf_we_o,
    output ybuf_addr_o,
    output ybuf_dat_o,
    input  xbuf_dat_i,
    input  fir_out_i
  );

  modport slave (
    input  xbuf_addr_o,
    input  fir_in_o,
    input  ybuf_we_o,
    input  ybuf_addr_o,
    input  ybuf_dat_o,
    output xbuf_dat_i,
    output fir_out_i
  );

endinterface

// File: rtl/fir_edge_det.sv
// Registered rising-edge detector: rise_o is high while d_i is high and was low last cycle.
module fir_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Remember the previous level of d_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: zero-flush, stream len samples through the filter and store the
// latency-aligned results, then flag completion with a sticky done and an irq pulse.
module fir_seq_ctrl import fir_pkg::*; #(
  parameter int unsigned DW  = FIR_DW,
  parameter int unsigned AW  = FIR_AW,
  parameter int unsigned LAT = FIR_LAT,
  parameter int unsigned CLR = FIR_CLR
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic [AW:0]    len_i,
  fir_seq_ctrl_if.master bus_io,
  output logic           busy_o,
  output logic           done_o,
  output logic           irq_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned LenW  = AW + 1;
  localparam int unsigned CntW  = $clog2(Depth + LAT + CLR + 1);

  localparam logic [CntW-1:0] LatC    = CntW'(LAT);
  localparam logic [CntW-1:0] ClrLast = CntW'((CLR > 0) ? CLR - 1 : 0);

  fir_seq_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [LenW-1:0] len_q, len_d;
  logic            done_q, done_d;
  logic            start_rise;
  logic [CntW-1:0] len_ext;
  logic [CntW-1:0] run_last;

  fir_edge_det u_start_edge (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (start_i),
    .rise_o (start_rise)
  );

  assign len_ext  = CntW'(len_q);
  assign run_last = len_ext + LatC - 1'b1;

  // Next-state logic; abort beats both progress and a coincident start.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) begin
          state_d = StIdle;
        end
        if (start_rise && !abort_i) begin
          len_d  = LenW'(fir_clamp_len(32'(len_i), Depth));
          cnt_d  = '0;
          done_d = 1'b0;
          if (len_d == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else if (CLR > 0) begin
            state_d = StClear;
          end else begin
            state_d = StRun;
          end
        end
      end
      StClear: begin
        if (abort_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == ClrLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (abort_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == run_last) begin
          state_d = StDone;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Datapath controls decoded from state and cycle count; idle values are all zero.
  always_comb begin
    bus_io.xbuf_addr_o = '0;
    bus_io.fir_in_o    = '0;
    bus_io.ybuf_we_o   = 1'b0;
    bus_io.ybuf_addr_o = '0;
    if (state_q == StRun) begin
      bus_io.xbuf_addr_o = cnt_q[AW-1:0];
      // Past the last sample the filter is fed zeros while its pipeline drains.
      if (cnt_q < len_ext) begin
        bus_io.fir_in_o = bus_io.xbuf_dat_i;
      end
      if ((cnt_q >= LatC) && (cnt_q < len_ext + LatC)) begin
        bus_io.ybuf_we_o   = 1'b1;
        bus_io.ybuf_addr_o = AW'(cnt_q - LatC);
      end
    end
  end

  assign bus_io.ybuf_dat_o = bus_io.fir_out_i;
  assign busy_o            = (state_q == StClear) || (state_q == StRun);
  assign done_o            = done_q;
  assign irq_o             = (state_q == StDone);

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl with a pure-delay filter model and flat buffers.
module tb_fir_seq_ctrl;
  import fir_pkg::*;

  localparam int unsigned DW  = FIR_DW;
  localparam int unsigned AW  = FIR_AW;
  localparam int unsigned LAT = FIR_LAT;
  localparam int unsigned CLR = FIR_CLR;
  localparam int          ObsW = 4 + 2 * AW + DW;

  logic          wb_clk_i  = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          start_i   = 1'b0;
  logic          abort_i   = 1'b0;
  logic [AW:0]   len_i     = '0;
  logic          busy_o;
  logic          done_o;
  logic          irq_o;

  fir_seq_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  fir_seq_ctrl #(
    .DW  (DW),
    .AW  (AW),
    .LAT (LAT),
    .CLR (CLR)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .len_i     (len_i),
    .bus_io    (bus),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .irq_o     (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Input buffer and LAT-stage pure-delay filter.
  logic [DW-1:0] xmem [32];
  logic [DW-1:0] pipe [LAT];

  assign bus.xbuf_dat_i = xmem[bus.xbuf_addr_o];
  assign bus.fir_out_i  = pipe[LAT-1];

  always @(posedge wb_clk_i) begin
    pipe[0] <= bus.fir_in_o;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  int n_vec = 0;
  int n_err = 0;

  // Per-run observations, cycle n = n-th cycle after the start edge.
  int            wr_cnt, busy_cnt, irq_cnt, irq_first, fin_cnt, done_at1;
  int            wr_addr [64];
  int            wr_cyc  [64];
  logic [DW-1:0] wr_dat  [64];

  task automatic run_obs(input int len, input int ncyc, input int abort_cyc, input int retrig_cyc);
    wr_cnt = 0; busy_cnt = 0; irq_cnt = 0; irq_first = -1; fin_cnt = 0; done_at1 = -1;
    @(negedge wb_clk_i);
    len_i   = len[AW:0];
    start_i = 1'b1;
    if (abort_cyc == 0) abort_i = 1'b1;
    @(posedge wb_clk_i);
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge wb_clk_i);
      if (busy_o) busy_cnt++;
      if (irq_o) begin
        irq_cnt++;
        if (irq_first < 0) irq_first = n;
      end
      if (n == 1) done_at1 = int'(done_o);
      if (bus.fir_in_o != '0) fin_cnt++;
      if (bus.ybuf_we_o && wr_cnt < 64) begin
        wr_addr[wr_cnt] = int'(bus.ybuf_addr_o);
        wr_dat[wr_cnt]  = bus.ybuf_dat_o;
        wr_cyc[wr_cnt]  = n;
        wr_cnt++;
      end
      if (n == 2) start_i = 1'b0;
      if (n == abort_cyc) abort_i = 1'b1;
      if (n == abort_cyc + 1) abort_i = 1'b0;
      if (n == retrig_cyc) start_i = 1'b1;
      if (n == retrig_cyc + 3) start_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [ObsW-1:0] obs;
    wb_rst_ni = 1'b0;
    #1;
    obs = {busy_o, done_o, irq_o, bus.ybuf_we_o, bus.xbuf_addr_o, bus.ybuf_addr_o, bus.fir_in_o};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
  endtask

  task automatic test_full_run();
    for (int k = 0; k < 32; k++) xmem[k] = DW'(k + 1);
    run_obs(32, 60, -10, -10);
    n_vec++; if (wr_cnt !== 32) begin n_err++; $display("FAIL full_writes: got %0d expected 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (wr_addr[k] !== k || wr_dat[k] !== DW'(k + 1)) begin
        n_err++;
        $display("FAIL full_word%0d: got addr %0d data %h expected addr %0d data %h",
                 k, wr_addr[k], wr_dat[k], k, k + 1);
      end
    end
    n_vec++; if (wr_cyc[0] !== 19) begin n_err++; $display("FAIL full_first_wr_cyc: got %0d expected 19", wr_cyc[0]); end
    n_vec++; if (busy_cnt !== 50) begin n_err++; $display("FAIL full_busy: got %0d expected 50", busy_cnt); end
    n_vec++; if (irq_cnt !== 1) begin n_err++; $display("FAIL full_irq_cnt: got %0d expected 1", irq_cnt); end
    n_vec++; if (irq_first !== 51) begin n_err++; $display("FAIL full_irq_cyc: got %0d expected 51", irq_first); end
    n_vec++; if (fin_cnt !== 32) begin n_err++; $display("FAIL full_fir_in: got %0d expected 32", fin_cnt); end
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL full_done: got %b expected 1", done_o); end
  endtask

  task automatic test_short_run();
    xmem[0] = 32'hDEAD_BEEF;
    run_obs(1, 30, -10, -10);
    n_vec++; if (done_at1 !== 0) begin n_err++; $display("FAIL short_done_cleared: got %0d expected 0", done_at1); end
    n_vec++; if (wr_cnt !== 1) begin n_err++; $display("FAIL short_writes: got %0d expected 1", wr_cnt); end
    n_vec++;
    if (wr_addr[0] !== 0 || wr_dat[0] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL short_word: got addr %0d data %h expected addr 0 data deadbeef", wr_addr[0], wr_dat[0]);
    end
    n_vec++; if (wr_cyc[0] !== 19) begin n_err++; $display("FAIL short_wr_cyc: got %0d expected 19", wr_cyc[0]); end
    n_vec++; if (fin_cnt !== 1) begin n_err++; $display("FAIL short_fir_in: got %0d expected 1", fin_cnt); end
    n_vec++; if (busy_cnt !== 19) begin n_err++; $display("FAIL short_busy: got %0d expected 19", busy_cnt); end
    n_vec++; if (irq_first !== 20) begin n_err++; $display("FAIL short_irq_cyc: got %0d expected 20", irq_first); end
  endtask

  task automatic test_zero_clamp();
    run_obs(0, 10, -10, -10);
    n_vec++; if (irq_first !== 1) begin n_err++; $display("FAIL zero_irq_cyc: got %0d expected 1", irq_first); end
    n_vec++; if (irq_cnt !== 1) begin n_err++; $display("FAIL zero_irq_cnt: got %0d expected 1", irq_cnt); end
    n_vec++; if (wr_cnt !== 0) begin n_err++; $display("FAIL zero_writes: got %0d expected 0", wr_cnt); end
    n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
    n_vec++; if (fin_cnt !== 0) begin n_err++; $display("FAIL zero_fir_in: got %0d expected 0", fin_cnt); end
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b expected 1", done_o); end
    for (int k = 0; k < 32; k++) xmem[k] = DW'(k + 1);
    run_obs(40, 60, -10, -10);
    n_vec++; if (wr_cnt !== 32) begin n_err++; $display("FAIL clamp_writes: got %0d expected 32", wr_cnt); end
    n_vec++; if (wr_addr[31] !== 31) begin n_err++; $display("FAIL clamp_last_addr: got %0d expected 31", wr_addr[31]); end
    n_vec++; if (irq_first !== 51) begin n_err++; $display("FAIL clamp_irq_cyc: got %0d expected 51", irq_first); end
  endtask

  task automatic test_abort();
    // RUN cycle 20 is cycle CLR + 20 + 1 = 31 after the start edge.
    run_obs(32, 60, 31, -10);
    n_vec++; if (wr_cnt !== 13) begin n_err++; $display("FAIL abort_writes: got %0d expected 13", wr_cnt); end
    n_vec++; if (wr_addr[12] !== 12) begin n_err++; $display("FAIL abort_last_addr: got %0d expected 12", wr_addr[12]); end
    n_vec++; if (busy_cnt !== 31) begin n_err++; $display("FAIL abort_busy: got %0d expected 31", busy_cnt); end
    n_vec++; if (irq_cnt !== 0) begin n_err++; $display("FAIL abort_irq: got %0d expected 0", irq_cnt); end
    n_vec++; if (done_o !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done_o); end
    // Abort coincident with a start edge drops the start.
    run_obs(32, 20, 0, -10);
    n_vec++; if (busy_cnt !== 0) begin n_err++; $display("FAIL abort_start_busy: got %0d expected 0", busy_cnt); end
    n_vec++; if (irq_cnt !== 0) begin n_err++; $display("FAIL abort_start_irq: got %0d expected 0", irq_cnt); end
  endtask

  task automatic test_retrigger();
    run_obs(32, 70, -10, 25);
    n_vec++; if (irq_cnt !== 1) begin n_err++; $display("FAIL retrig_irq_cnt: got %0d expected 1", irq_cnt); end
    n_vec++; if (irq_first !== 51) begin n_err++; $display("FAIL retrig_irq_cyc: got %0d expected 51", irq_first); end
    n_vec++; if (wr_cnt !== 32) begin n_err++; $display("FAIL retrig_writes: got %0d expected 32", wr_cnt); end
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL retrig_done: got %b expected 1", done_o); end
    for (int k = 0; k < 32; k++) xmem[k] = ~DW'(k);
    run_obs(32, 60, -10, -10);
    n_vec++; if (done_at1 !== 0) begin n_err++; $display("FAIL rerun_done_cleared: got %0d expected 0", done_at1); end
    n_vec++; if (wr_cnt !== 32) begin n_err++; $display("FAIL rerun_writes: got %0d expected 32", wr_cnt); end
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (wr_addr[k] !== k || wr_dat[k] !== ~DW'(k)) begin
        n_err++;
        $display("FAIL rerun_word%0d: got addr %0d data %h expected addr %0d data %h",
                 k, wr_addr[k], wr_dat[k], k, ~DW'(k));
      end
    end
    n_vec++; if (irq_first !== 51) begin n_err++; $display("FAIL rerun_irq_cyc: got %0d expected 51", irq_first); end
  endtask

  task automatic test_reset_midrun();
    logic [ObsW-1:0] obs;
    @(negedge wb_clk_i);
    len_i   = 6'd32;
    start_i = 1'b1;
    @(posedge wb_clk_i);
    repeat (20) @(posedge wb_clk_i);
    #2;
    // Cycle 21 is RUN cycle 10, where a write is in progress.
    n_vec++; if (bus.ybuf_we_o !== 1'b1) begin n_err++; $display("FAIL midrun_we: got %b expected 1", bus.ybuf_we_o); end
    wb_rst_ni = 1'b0;
    #1;
    obs = {busy_o, done_o, irq_o, bus.ybuf_we_o, bus.xbuf_addr_o, bus.ybuf_addr_o, bus.fir_in_o};
    n_vec++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL midrun_reset_outputs: got %h expected 0", obs);
    end
    start_i = 1'b0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    for (int k = 0; k < 32; k++) xmem[k] = DW'(32'h100 + k);
    run_obs(4, 30, -10, -10);
    n_vec++; if (wr_cnt !== 4) begin n_err++; $display("FAIL post_reset_writes: got %0d expected 4", wr_cnt); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (wr_addr[k] !== k || wr_dat[k] !== DW'(32'h100 + k)) begin
        n_err++;
        $display("FAIL post_reset_word%0d: got addr %0d data %h expected addr %0d data %h",
                 k, wr_addr[k], wr_dat[k], k, 32'h100 + k);
      end
    end
    n_vec++; if (irq_first !== 23) begin n_err++; $display("FAIL post_reset_irq_cyc: got %0d expected 23", irq_first); end
    n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL post_reset_done: got %b expected 1", done_o); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_short_run();
    test_zero_clamp();
    test_abort();
    test_retrigger();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
# fir_seq_ctrl

Sequencer for the FIR filter datapath in the FIR Wishbone peripheral. On a start request it flushes the filter with zeros, streams a programmable number of samples from the input buffer into the filter, and writes the aligned filter outputs into the output buffer. When the block is finished it reports done and pulses an interrupt. It replaces free-running select counters with a single FSM that has explicit length, latency, abort and completion semantics.

## Interface
Parameters:
- DW, 32, sample/data width
- AW, 5, buffer address width (depth 2**AW = 32)
- LAT, 8, filter latency: cycles from a sample on fir_in_o to its result on fir_out_i
- CLR, 10, zero-flush cycles before streaming (0 = no flush)

Ports:
- wb_clk_i  in  1  clock. Single clock domain.
- wb_rst_ni  in  1  reset. Asynchronous, active-low.
- start_i  in  1  start level from the register file. A rising edge requests a run.
- abort_i  in  1  abort. Level, sampled each clock.
- len_i  in  AW+1  sample count, 0..32. Values above 32 clamp to 32. Latched on an accepted start.
- xbuf_addr_o  out  AW  input buffer read address
- xbuf_dat_i  in  DW  input buffer data. Combinational read of xbuf_addr_o.
- fir_in_o  out  DW  filter input sample
- fir_out_i  in  DW  filter output
- ybuf_we_o  out  1  output buffer write enable, one word per cycle
- ybuf_addr_o  out  AW  output buffer write address
- ybuf_dat_o  out  DW  output buffer write data, equal to fir_out_i
- busy_o  out  1  high in CLEAR and RUN
- done_o  out  1  sticky completion flag
- irq_o  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE. Counter cnt is wide enough to hold 2**AW+LAT+CLR.
- Start edge detection:
  - start_r is start_i registered.
  - A start is accepted when start_i & ~start_r in IDLE or DONE.
  - Edges in CLEAR or RUN are dropped, not queued.
- On an accepted start:
  - Latch len = min(len_i, 32).
  - Clear done_o and cnt.
  - Go to CLEAR if CLR>0, else to RUN.
  - If len=0, go to DONE directly.
- CLEAR:
  - fir_in_o=0, ybuf_we_o=0.
  - Runs CLR cycles, then goes to RUN with cnt=0.
- RUN, at cycle k = cnt:
  - xbuf_addr_o = k[AW-1:0].
  - fir_in_o = xbuf_dat_i if k<len, else 0.
  - ybuf_we_o = 1 when LAT ≤ k < LAT+len. In that case ybuf_addr_o = k-LAT.
  - After cycle k = len+LAT-1, go to DONE.
- DONE:
  - One cycle: irq_o=1, done_o set (held until the next accepted start).
  - Then go to IDLE.
- Abort:
  - abort_i high at a clock edge in CLEAR or RUN forces IDLE.
  - done_o stays 0 and no irq_o pulse is generated.
  - A write already asserted in the abort cycle completes. No writes occur after that edge.
  - If abort_i and a start edge occur at the same edge, abort wins and the start is dropped.
- All combinational outputs derive from registered state and cnt only (plus xbuf_dat_i and fir_out_i passthrough).

## Timing
- Reset values: busy_o=0, done_o=0, irq_o=0, ybuf_we_o=0, xbuf_addr_o=0, ybuf_addr_o=0, fir_in_o=0. Internal state is IDLE, cnt=0, start_r=0.
- Reset asserted mid-run: all outputs take their reset values asynchronously. No partial completion is signalled.
- Start edge seen at edge T:
  - busy_o rises after T.
  - CLEAR spans CLR cycles.
  - RUN spans len+LAT cycles.
  - irq_o is high for exactly one cycle, after the RUN → DONE transition.
- Total run from start edge to irq_o: CLR+len+LAT+1 cycles. Defaults with len=32: 51 cycles.
- len=0: irq_o follows one cycle after the start edge. No fir_in_o activity and no writes.
- Exactly len writes per completed run, to addresses 0..len-1 in ascending order.

## Structure
- Package fir_pkg holds:
  - State enum fir_seq_state_t (IDLE, CLEAR, RUN, DONE).
  - Default constants FIR_DW, FIR_AW, FIR_LAT, FIR_CLR.
  - Function fir_clamp_len.
- One sub-module: fir_edge_det (registered rising-edge detector, async active-low reset), used for start_i.
- Buffers and the filter stay outside this block.

## Test plan
Bench filter model: pure LAT-cycle delay.

- Full run: len=32, x[k]=k+1, start edge → ybuf[k]=k+1 for k=0..31. 32 writes, busy_o high for 50 cycles, one irq_o pulse at T+51, done_o=1.
- Short run: len=1, x[0]=0xDEADBEEF → single write ybuf[0]=0xDEADBEEF at RUN cycle 8. fir_in_o=0 in all other cycles.
- Zero and clamp:
  - len=0 → irq_o at T+1, no writes.
  - len=40 → exactly 32 writes.
- Abort: len=32, assert abort_i at RUN cycle 20 → 13 writes (addr 0..12, the abort-cycle write included), then IDLE, done_o=0, no irq_o.
- Retrigger: start toggled low/high during RUN → ignored, single irq_o. A new start edge after DONE clears done_o and reruns correctly.
- Reset: drop wb_rst_ni mid-RUN → all outputs at reset values immediately. A post-reset run with len=4 completes normally.
